// File: rtl/bft_pkg.sv
// Shared BFT definitions: packet layout, receiver buffer depth and control port code,
// reused by both the sender and the leaf-side blocks.
package bft_pkg;

    localparam int BFT_PACKET_BITS  = 49;
    localparam int BFT_PAYLOAD_BITS = 32;
    localparam int BFT_LEAF_BITS    = 5;
    localparam int BFT_PORT_BITS    = 4;
    localparam int BFT_ADDR_BITS    = 7;
    localparam int BFT_DEPTH        = 2 ** BFT_ADDR_BITS;

    localparam int VLD_BIT  = 48;
    localparam int LEAF_LSB = 43;
    localparam int PORT_LSB = 39;
    localparam int ADDR_LSB = 32;

    localparam logic [BFT_PORT_BITS-1:0] CTRL_PORT = '0;

    typedef struct packed {
        logic                        vld;
        logic [BFT_LEAF_BITS-1:0]    leaf;
        logic [BFT_PORT_BITS-1:0]    port;
        logic [BFT_ADDR_BITS-1:0]    addr;
        logic [BFT_PAYLOAD_BITS-1:0] payload;
    } bft_packet_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } sender_state_t;

endpackage

// File: rtl/bft_stream_sender_if.sv
// AXI-stream style word handshake between a producer (master) and the BFT sender (slave).
interface bft_stream_sender_if #(
    parameter int DATA_BITS = 32
);
    logic [DATA_BITS-1:0] TDATA;
    logic                 TVALID;
    logic                 TREADY;

    modport master (output TDATA, output TVALID, input TREADY);
    modport slave  (input TDATA, input TVALID, output TREADY);
endinterface

// File: rtl/bft_credit_counter.sv
// Saturating credit register for the leaf receive buffer, with a sticky overflow flag.
module bft_credit_counter
    import bft_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send,
    input  logic [7:0] upd,
    output logic [7:0] credit,
    output logic       credit_err
);

    localparam logic [8:0] MAX_CREDIT = 9'(BFT_DEPTH);

    logic [8:0] credit_next;

    // Nine bits so an oversized update is visible before saturation.
    assign credit_next = {1'b0, credit} - {8'd0, send} + {1'b0, upd};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit     <= MAX_CREDIT[7:0];
            credit_err <= 1'b0;
        end else if (credit_next > MAX_CREDIT) begin
            credit     <= MAX_CREDIT[7:0];
            credit_err <= 1'b1;
        end else begin
            credit     <= credit_next[7:0];
        end
    end

endmodule

// File: rtl/bft_stream_sender.sv
// Packs stream words into BFT packets for one destination leaf port under credit control.
// Define BFT_SENDER_STATS_EN to add the pkt_count and stall_count outputs.
module bft_stream_sender
    import bft_pkg::*;
#(
    parameter int PACKET_BITS   = BFT_PACKET_BITS,
    parameter int PAYLOAD_BITS  = BFT_PAYLOAD_BITS,
    parameter int NUM_LEAF_BITS = BFT_LEAF_BITS,
    parameter int NUM_PORT_BITS = BFT_PORT_BITS,
    parameter int NUM_ADDR_BITS = BFT_ADDR_BITS,
    parameter logic [NUM_LEAF_BITS-1:0] SELF_LEAF = '0
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     ap_start,
    input  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf,
    input  logic [NUM_PORT_BITS-1:0] cfg_dest_port,
    bft_stream_sender_if.slave       s,
    input  logic [PACKET_BITS-1:0]   din_leaf_bft2sender,
    output logic [PACKET_BITS-1:0]   dout_sender2bft,
    output logic [7:0]               credit,
`ifdef BFT_SENDER_STATS_EN
    output logic [31:0]              pkt_count,
    output logic [31:0]              stall_count,
`endif
    output logic                     credit_err
);

    sender_state_t            state;
    sender_state_t            state_next;
    logic [NUM_LEAF_BITS-1:0] dest_leaf;
    logic [NUM_PORT_BITS-1:0] dest_port;
    logic [NUM_ADDR_BITS-1:0] wr_addr;
    logic                     send;
    logic                     upd_hit;
    logic [7:0]               upd_amount;
    logic                     unused_din;
    bft_packet_t              tx_pkt;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        s.TREADY   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ap_start) state_next = ST_RUN;
            end
            ST_RUN: begin
                s.TREADY = (credit != 8'd0);
                if (!ap_start) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign send = s.TVALID & s.TREADY;

    // Freespace updates come back addressed to our own leaf on the control port.
    assign upd_hit = din_leaf_bft2sender[VLD_BIT]
                  && (din_leaf_bft2sender[LEAF_LSB +: NUM_LEAF_BITS] == SELF_LEAF)
                  && (din_leaf_bft2sender[PORT_LSB +: NUM_PORT_BITS] == CTRL_PORT);
    assign upd_amount = upd_hit ? din_leaf_bft2sender[7:0] : 8'd0;
    assign unused_din = ^din_leaf_bft2sender[ADDR_LSB+NUM_ADDR_BITS-1:8];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            dest_leaf <= '0;
            dest_port <= '0;
        end else if (state == ST_IDLE && ap_start) begin
            dest_leaf <= cfg_dest_leaf;
            dest_port <= cfg_dest_port;
        end
    end

    assign tx_pkt = '{vld: 1'b1, leaf: dest_leaf, port: dest_port,
                      addr: wr_addr, payload: s.TDATA[PAYLOAD_BITS-1:0]};

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            dout_sender2bft <= '0;
            wr_addr         <= '0;
        end else begin
            dout_sender2bft <= send ? tx_pkt : '0;
            if (send) wr_addr <= wr_addr + NUM_ADDR_BITS'(1);
        end
    end

    bft_credit_counter u_credit (
        .clk        (ap_clk),
        .rst_n      (ap_rst_n),
        .send       (send),
        .upd        (upd_amount),
        .credit     (credit),
        .credit_err (credit_err)
    );

`ifdef BFT_SENDER_STATS_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            pkt_count   <= '0;
            stall_count <= '0;
        end else begin
            if (send) pkt_count <= pkt_count + 32'd1;
            if (state == ST_RUN && s.TVALID && credit == 8'd0)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule
